// File: rtl/gb_host_seq_if.sv
// rtl/gb_host_seq_if.sv - host request/response and ghostbus signal bundle for gb_host_seq
interface gb_host_if #(
   parameter int GB_AW = 24,
   parameter int GB_DW = 32
);
   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [GB_AW-1:0] req_addr;
   logic [GB_DW-1:0] req_wdata;
   logic             resp_valid;
   logic             resp_ready;
   logic [GB_DW-1:0] resp_rdata;
   logic             resp_write;
   logic [GB_AW-1:0] gb_addr;
   logic [GB_DW-1:0] gb_wdata;
   logic             gb_wen;
   logic             gb_rstb;
   logic [GB_DW-1:0] gb_rdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready, gb_rdata,
      output req_ready, resp_valid, resp_rdata, resp_write,
             gb_addr, gb_wdata, gb_wen, gb_rstb
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, resp_ready, gb_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_write,
             gb_addr, gb_wdata, gb_wen, gb_rstb
   );
endinterface

// File: rtl/gb_host_seq.sv
// rtl/gb_host_seq.sv - single-outstanding host-to-ghostbus sequencer with fixed read latency
// Optional write acknowledge responses: define GB_HOST_WACK_EN.
module gb_host_seq #(
   parameter int GB_AW = 24,
   parameter int GB_DW = 32,
   parameter int RD    = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   gb_host_if.master bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WSTB  = 3'd1;
   localparam logic [2:0] S_RSTB  = 3'd2;
   localparam logic [2:0] S_RWAIT = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   localparam logic [3:0] CNT_LOAD = 4'(RD - 1);

   logic [2:0] state;
   logic [3:0] cnt;
   logic       accept;

   // Gated by rst_n so the host never sees ready while reset is asserted.
   assign bus.req_ready = rst_n && (state == S_IDLE);
   assign accept        = bus.req_valid && bus.req_ready;

`ifndef GB_HOST_WACK_EN
   assign bus.resp_write = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         cnt            <= 4'd0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
`ifdef GB_HOST_WACK_EN
         bus.resp_write <= 1'b0;
`endif
         bus.gb_addr    <= '0;
         bus.gb_wdata   <= '0;
         bus.gb_wen     <= 1'b0;
         bus.gb_rstb    <= 1'b0;
      end else begin
         bus.gb_wen  <= 1'b0;
         bus.gb_rstb <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  bus.gb_addr  <= bus.req_addr;
                  bus.gb_wdata <= bus.req_wdata;
                  if (bus.req_write) begin
                     bus.gb_wen <= 1'b1;
                     state      <= S_WSTB;
                  end else begin
                     bus.gb_rstb <= 1'b1;
                     state       <= S_RSTB;
                  end
               end
            end
            S_WSTB: begin
`ifdef GB_HOST_WACK_EN
               bus.resp_valid <= 1'b1;
               bus.resp_write <= 1'b1;
               bus.resp_rdata <= '0;
               state          <= S_RESP;
`else
               state          <= S_IDLE;
`endif
            end
            S_RSTB: begin
               cnt   <= CNT_LOAD;
               state <= S_RWAIT;
            end
            // Capture lands RD cycles after the strobe cycle, so RD=1 still spends one cycle here.
            S_RWAIT: begin
               if (cnt == 4'd0) begin
                  bus.resp_rdata <= bus.gb_rdata;
                  bus.resp_valid <= 1'b1;
`ifdef GB_HOST_WACK_EN
                  bus.resp_write <= 1'b0;
`endif
                  state          <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  bus.resp_valid <= 1'b0;
                  state          <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gb_host_seq.sv
// tb/tb_gb_host_seq.sv - scoreboard bench for gb_host_seq (optionally built with GB_HOST_WACK_EN)
module tb_gb_host_seq;
   localparam int AW = 24;
   localparam int DW = 32;
   localparam int RD = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   logic prev_rv = 1'b0;
   logic [15:0] rpipe = '0;

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            c;
   } strb_t;
   typedef struct {
      logic          w;
      logic [DW-1:0] d;
      int            c;
   } rsp_t;

   strb_t sq[$];
   rsp_t  rq[$];

   always #5 clk = ~clk;

   gb_host_if #(.GB_AW(AW), .GB_DW(DW)) bus();

   gb_host_seq #(.GB_AW(AW), .GB_DW(DW), .RD(RD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [DW-1:0] model(input logic [AW-1:0] a);
      if (a == 24'h000004) return 32'h12345678;
      return {a[7:0], ~a[7:0], a[15:8], 8'h5A};
   endfunction

   // Read data is only valid RD cycles after the strobe; otherwise a poison value.
   always @(posedge clk) rpipe <= {rpipe[14:0], bus.gb_rstb};
   assign bus.gb_rdata = rpipe[RD-1] ? model(bus.gb_addr) : 32'hBADBAD00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.gb_wen && bus.gb_rstb) check("strb_excl", 1, 0);
         if (bus.gb_wen || bus.gb_rstb) begin
            if (sq.size() == 0) check("strb_unexp", 1, 0);
            else begin
               strb_t s;
               s = sq.pop_front();
               check("strb_kind", bus.gb_wen, s.w);
               check("strb_addr", bus.gb_addr, s.a);
               if (s.w) check("strb_wdata", bus.gb_wdata, s.d);
               check("strb_cyc", cyc, s.c);
            end
         end
         if (bus.resp_valid) begin
            check("busy_ready", bus.req_ready, 0);
            if (rq.size() == 0) check("resp_unexp", 1, 0);
            else begin
               check("resp_rdata", bus.resp_rdata, rq[0].d);
               check("resp_write", bus.resp_write, rq[0].w);
               if (!prev_rv) check("resp_cyc", cyc, rq[0].c);
               if (bus.resp_ready) void'(rq.pop_front());
            end
         end
         prev_rv = bus.resp_valid;
      end else begin
         prev_rv = 1'b0;
      end
   end

   // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      int acc;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         check("req_timeout", 0, 1);
         bus.req_valid = 1'b0;
      end else begin
         acc = cyc + 1;
         sq.push_back('{w: w, a: a, d: d, c: acc});
         if (!w) rq.push_back('{w: 1'b0, d: model(a), c: acc + RD + 1});
`ifdef GB_HOST_WACK_EN
         if (w) rq.push_back('{w: 1'b1, d: '0, c: acc + 1});
`endif
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      bus.req_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((sq.size() != 0 || rq.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, sq.size() + rq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"},  bus.req_ready, 0);
      check({tag, "_rvalid"}, bus.resp_valid, 0);
      check({tag, "_rdata"},  bus.resp_rdata, 0);
      check({tag, "_rwrite"}, bus.resp_write, 0);
      check({tag, "_addr"},   bus.gb_addr, 0);
      check({tag, "_wdata"},  bus.gb_wdata, 0);
      check({tag, "_wen"},    bus.gb_wen, 0);
      check({tag, "_rstb"},   bus.gb_rstb, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b1;

      @(posedge clk);
      #1;
      check_all_zero("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_ready", bus.req_ready, 1);

      send(1'b1, 24'h000010, 32'hDEADBEEF);
      idle();
      @(negedge clk);
      check("wr_busy", bus.req_ready, 0);
`ifndef GB_HOST_WACK_EN
      @(negedge clk);
      check("wr_ready_back", bus.req_ready, 1);
`endif
      drain("wr_drain");

      send(1'b0, 24'h000004, 32'h0);
      idle();
      drain("rd_drain");

      bus.resp_ready = 1'b0;
      send(1'b0, 24'h000020, 32'h0);
      idle();
      repeat (RD + 8) @(posedge clk);
      #1;
      check("stall_hold", bus.resp_valid, 1);
      check("stall_rdata", bus.resp_rdata, model(24'h000020));
      bus.resp_ready = 1'b1;
      drain("stall_drain");

`ifdef GB_HOST_WACK_EN
      bus.resp_ready = 1'b0;
      send(1'b1, 24'h000060, 32'hCAFEF00D);
      idle();
      repeat (6) @(posedge clk);
      #1;
      check("wack_hold", bus.resp_valid, 1);
      bus.resp_ready = 1'b1;
      drain("wack_drain");
`endif

      send(1'b1, 24'h000030, 32'hA5A5_0001);
      send(1'b0, 24'h000044, 32'h0);
      idle();
      drain("b2b_drain");

      for (int i = 0; i < 8; i++) begin
         logic [AW-1:0] a;
         a = AW'($urandom);
         send(1'($urandom_range(0, 1)), a, $urandom);
      end
      idle();
      drain("rand_drain");

      send(1'b0, 24'h000050, 32'h0);
      idle();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      sq.delete();
      rq.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(1'b0, 24'h000004, 32'h0);
      idle();
      drain("postrst_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
